rv32i_mem_stage_hs: RTL and testbench

RV32I_MEM_STAGE_HS -- requirements
Module: rv32i_mem_stage_hs

---
 rtl/rv32i_mem_stage_hs_if.sv | 25 ++
 rtl/rv32i_mem_stage_hs.sv | 228 ++++++++++++++++++++++
 tb/tb_rv32i_mem_stage_hs.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_stage_hs_if.sv
// rv32i_mem_stage_hs_if -- one load/store bus port of the RV32I memory stage.
// The stage owns two of these (memory and IO).
//   req   : access request, held high until ack or abandonment
//   we    : 1 = write, 0 = read
//   be    : byte-lane enables
//   addr  : word address (byte address bits [31:2])
//   wdata : write data, already replicated into the enabled lanes
//   rdata : read data, sampled in the ack cycle
//   ack   : completion strobe from the target
// Handshake: the master raises req with we/be/addr/wdata and keeps them
// stable until the target pulses ack for one cycle. The access completes on
// the rising edge where req and ack are both high. The master may also drop
// req on its own after a timeout; an ack arriving after that is ignored.
interface rv32i_mem_stage_hs_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [29:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, be, addr, wdata, input rdata, ack);
   modport slave  (input req, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/rv32i_mem_stage_hs.sv
// rv32i_mem_stage_hs -- RV32I memory stage with a request/ack bus port.
// The stage passes ALU results through in one cycle. It rejects misaligned
// or unsupported-width accesses in one cycle. Aligned loads and stores go to
// the memory or IO port, selected by address bit IO_SEL_BIT. While an access
// is outstanding, the stage stalls upstream until ack or timeout.
// Ports:
//   clk, reset             : clock, async active-high reset
//   valid_in .. wb_reg_in  : EX-side operation (held by upstream while stall_out)
//   stall_out              : high while an access is outstanding (state WAIT)
//   mem, io                : bus ports (master side)
//   valid_out .. misalign  : WB-side result; valid/fault/misalign are 1-cycle pulses
//   df_mem_*               : forwarding view of the WB-side result
//   state_dbg              : current FSM state (0 IDLE, 1 WAIT)
module rv32i_mem_stage_hs #(
   parameter int IO_SEL_BIT = 31,
   parameter int TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] iw_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] rs2_data_in,
   input  logic        w_en_in,
   input  logic        wb_en_in,
   input  logic [4:0]  wb_reg_in,
   output logic        stall_out,
   rv32i_mem_stage_hs_if.master mem,
   rv32i_mem_stage_hs_if.master io,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] iw_out,
   output logic [31:0] wb_data_out,
   output logic        wb_en_out,
   output logic [4:0]  wb_reg_out,
   output logic        fault_out,
   output logic        misalign_out,
   output logic        df_mem_enable,
   output logic [4:0]  df_mem_reg,
   output logic [31:0] df_mem_data,
   output logic        state_dbg
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   // WAIT cycles are counted from 0; the last allowed one has count TIMEOUT-1.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;

   // Operation captured at the start of an access.
   logic [31:0] cap_pc, cap_iw, cap_alu;
   logic [4:0]  cap_wb_reg;
   logic        cap_wb_en, cap_load, cap_io;

   // Bus request registers shared by both ports; only the selected port sees them.
   logic        req_q, we_q;
   logic [3:0]  be_q;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;

   // Decode of the incoming operation.
   logic [2:0]  f3;
   logic        is_store, is_load, is_ls, bad_width, misalign;
   logic [3:0]  new_be;
   logic [31:0] new_wdata;

   always_comb begin
      f3        = iw_in[14:12];
      is_store  = w_en_in;
      is_load   = (iw_in[6:0] == 7'b0000011) && !w_en_in;
      is_ls     = is_load || is_store;
      // 011, 110 and 111 are not legal load/store widths; reject like misaligned.
      bad_width = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      misalign  = bad_width
                  || (f3[1:0] == 2'b01 && alu_in[0])
                  || (f3[1:0] == 2'b10 && alu_in[1:0] != 2'b00);
      new_be    = 4'b1111;
      new_wdata = 32'h0;
      if (is_store) begin
         case (f3[1:0])
            2'b00: begin
               new_be    = 4'b0001 << alu_in[1:0];
               new_wdata = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
               new_be    = 4'b0011 << alu_in[1:0];
               new_wdata = {2{rs2_data_in[15:0]}};
            end
            default: begin
               new_be    = 4'b1111;
               new_wdata = rs2_data_in;
            end
         endcase
      end
   end

   // Response from the selected port; the other port is ignored entirely.
   logic        sel_ack;
   logic [31:0] sel_rdata, shifted;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   always_comb begin
      sel_ack   = cap_io ? io.ack : mem.ack;
      sel_rdata = cap_io ? io.rdata : mem.rdata;
      shifted   = sel_rdata >> {cap_alu[1:0], 3'b000};
      ld_byte   = shifted[7:0];
      ld_half   = cap_alu[1] ? sel_rdata[31:16] : sel_rdata[15:0];
      case (cap_iw[14:12])
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_data = {24'h0, ld_byte};
         3'b101:  load_data = {16'h0, ld_half};
         default: load_data = sel_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= 8'd0;
         cap_pc       <= 32'h0;
         cap_iw       <= 32'h0;
         cap_alu      <= 32'h0;
         cap_wb_reg   <= 5'd0;
         cap_wb_en    <= 1'b0;
         cap_load     <= 1'b0;
         cap_io       <= 1'b0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         be_q         <= 4'h0;
         addr_q       <= 30'h0;
         wdata_q      <= 32'h0;
         valid_out    <= 1'b0;
         pc_out       <= 32'h0;
         iw_out       <= 32'h0;
         wb_data_out  <= 32'h0;
         wb_en_out    <= 1'b0;
         wb_reg_out   <= 5'd0;
         fault_out    <= 1'b0;
         misalign_out <= 1'b0;
      end else begin
         valid_out    <= 1'b0;
         fault_out    <= 1'b0;
         misalign_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (valid_in) begin
                  if (!is_ls || misalign) begin
                     valid_out    <= 1'b1;
                     misalign_out <= is_ls;
                     wb_en_out    <= is_ls ? 1'b0 : wb_en_in;
                     pc_out       <= pc_in;
                     iw_out       <= iw_in;
                     wb_reg_out   <= wb_reg_in;
                     wb_data_out  <= alu_in;
                  end else begin
                     cap_pc     <= pc_in;
                     cap_iw     <= iw_in;
                     cap_alu    <= alu_in;
                     cap_wb_reg <= wb_reg_in;
                     cap_wb_en  <= wb_en_in;
                     cap_load   <= is_load;
                     cap_io     <= alu_in[IO_SEL_BIT];
                     req_q      <= 1'b1;
                     we_q       <= is_store;
                     be_q       <= new_be;
                     addr_q     <= alu_in[31:2];
                     wdata_q    <= new_wdata;
                     cnt        <= 8'd0;
                     state      <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // Ack is checked before the timeout, so an ack in the last allowed cycle wins.
               if (sel_ack || cnt == LAST_CNT) begin
                  req_q      <= 1'b0;
                  state      <= S_IDLE;
                  valid_out  <= 1'b1;
                  pc_out     <= cap_pc;
                  iw_out     <= cap_iw;
                  wb_reg_out <= cap_wb_reg;
                  if (sel_ack && cap_load) begin
                     wb_data_out <= load_data;
                     wb_en_out   <= cap_wb_en;
                  end else begin
                     wb_data_out <= cap_alu;
                     wb_en_out   <= 1'b0;
                  end
                  fault_out <= !sel_ack;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outside an access both ports show all-zero request fields.
   logic mem_act, io_act;
   assign mem_act   = req_q && !cap_io;
   assign io_act    = req_q && cap_io;

   assign mem.req   = mem_act;
   assign mem.we    = mem_act && we_q;
   assign mem.be    = mem_act ? be_q : 4'h0;
   assign mem.addr  = mem_act ? addr_q : 30'h0;
   assign mem.wdata = mem_act ? wdata_q : 32'h0;

   assign io.req    = io_act;
   assign io.we     = io_act && we_q;
   assign io.be     = io_act ? be_q : 4'h0;
   assign io.addr   = io_act ? addr_q : 30'h0;
   assign io.wdata  = io_act ? wdata_q : 32'h0;

   assign stall_out     = (state == S_WAIT);
   assign state_dbg     = state;
   assign df_mem_enable = valid_out && wb_en_out;
   assign df_mem_reg    = wb_reg_out;
   assign df_mem_data   = wb_data_out;

endmodule

// File: tb/tb_rv32i_mem_stage_hs.sv
module tb_rv32i_mem_stage_hs;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
   logic        w_en_in, wb_en_in;
   logic [4:0]  wb_reg_in;
   logic        stall_out, valid_out, wb_en_out, fault_out, misalign_out;
   logic [31:0] pc_out, iw_out, wb_data_out, df_mem_data;
   logic [4:0]  wb_reg_out, df_mem_reg;
   logic        df_mem_enable, state_dbg;

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [31:0] IW_ALU = 32'h0000_0013;
   localparam logic [31:0] IW_LB  = 32'h0000_0083;
   localparam logic [31:0] IW_LH  = 32'h0000_1083;
   localparam logic [31:0] IW_LW  = 32'h0000_2083;
   localparam logic [31:0] IW_LX3 = 32'h0000_3083;
   localparam logic [31:0] IW_LHU = 32'h0000_5083;
   localparam logic [31:0] IW_SB  = 32'h0000_0023;
   localparam logic [31:0] IW_SH  = 32'h0000_1023;

   rv32i_mem_stage_hs_if mem_bus ();
   rv32i_mem_stage_hs_if io_bus ();

   rv32i_mem_stage_hs #(.IO_SEL_BIT(31), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .valid_in(valid_in), .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in),
      .rs2_data_in(rs2_data_in), .w_en_in(w_en_in), .wb_en_in(wb_en_in),
      .wb_reg_in(wb_reg_in), .stall_out(stall_out),
      .mem(mem_bus), .io(io_bus),
      .valid_out(valid_out), .pc_out(pc_out), .iw_out(iw_out),
      .wb_data_out(wb_data_out), .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out),
      .fault_out(fault_out), .misalign_out(misalign_out),
      .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
      .df_mem_data(df_mem_data), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver
   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] iw,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic we,
                        input logic wbe, input logic [4:0] rd);
      valid_in = v; pc_in = pc; iw_in = iw; alu_in = alu;
      rs2_data_in = rs2; w_en_in = we; wb_en_in = wbe; wb_reg_in = rd;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
      io_bus.ack  = 1'b0; io_bus.rdata  = 32'h0;
      step(); step();
      chk("rst_valid", valid_out, 0);
      chk("rst_mem_req", mem_bus.req, 0);
      chk("rst_io_req", io_bus.req, 0);
      chk("rst_stall", stall_out, 0);
      chk("rst_wb_data", wb_data_out, 0);
      chk("rst_pc", pc_out, 0);
      reset = 1'b0;
      step();

      // ALU pass-through
      drive(1'b1, 32'h100, IW_ALU, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5);
      step();
      chk("alu_valid", valid_out, 1);
      chk("alu_data", wb_data_out, 32'h1234);
      chk("alu_pc", pc_out, 32'h100);
      chk("alu_mem_req", mem_bus.req, 0);
      chk("alu_io_req", io_bus.req, 0);
      chk("alu_df_en", df_mem_enable, 1);
      chk("alu_df_reg", df_mem_reg, 5);
      chk("alu_df_data", df_mem_data, 32'h1234);
      idle();
      step();
      chk("alu_pulse", valid_out, 0);
      chk("alu_hold", wb_data_out, 32'h1234);

      // LB a=3, ack in the third WAIT cycle; next op held during WAIT
      drive(1'b1, 32'h104, IW_LB, 32'h3, 32'h0, 1'b0, 1'b1, 5'd6);
      step();
      drive(1'b1, 32'h108, IW_ALU, 32'h55, 32'h0, 1'b0, 1'b1, 5'd7);
      chk("lb_w1_req", mem_bus.req, 1);
      chk("lb_w1_io", io_bus.req, 0);
      chk("lb_w1_stall", stall_out, 1);
      chk("lb_be", mem_bus.be, 4'b1111);
      chk("lb_we", mem_bus.we, 0);
      chk("lb_addr", mem_bus.addr, 0);
      chk("lb_w1_valid", valid_out, 0);
      step();
      chk("lb_w2_req", mem_bus.req, 1);
      chk("lb_w2_stall", stall_out, 1);
      step();
      chk("lb_w3_req", mem_bus.req, 1);
      chk("lb_w3_stall", stall_out, 1);
      mem_bus.rdata = 32'h80FF_0000; mem_bus.ack = 1'b1;
      step();
      mem_bus.ack = 1'b0;
      chk("lb_valid", valid_out, 1);
      chk("lb_data", wb_data_out, 32'hFFFF_FF80);
      chk("lb_pc", pc_out, 32'h104);
      chk("lb_wb_en", wb_en_out, 1);
      chk("lb_req_off", mem_bus.req, 0);
      chk("lb_stall_off", stall_out, 0);
      chk("lb_fault", fault_out, 0);
      step();
      idle();
      chk("held_valid", valid_out, 1);
      chk("held_pc", pc_out, 32'h108);
      chk("held_data", wb_data_out, 32'h55);
      step();
      chk("held_once", valid_out, 0);

      // SH to IO, a stray memory ack must be ignored
      drive(1'b1, 32'h200, IW_SH, 32'h8000_0002, 32'h0000_BEEF, 1'b1, 1'b0, 5'd0);
      step();
      idle();
      chk("sh_io_req", io_bus.req, 1);
      chk("sh_io_be", io_bus.be, 4'b1100);
      chk("sh_io_wdata", io_bus.wdata, 32'hBEEF_BEEF);
      chk("sh_io_we", io_bus.we, 1);
      chk("sh_io_addr", io_bus.addr, 30'h2000_0000);
      chk("sh_mem_req", mem_bus.req, 0);
      mem_bus.ack = 1'b1;
      step();
      mem_bus.ack = 1'b0;
      chk("sh_stray_ack", valid_out, 0);
      chk("sh_still_req", io_bus.req, 1);
      io_bus.ack = 1'b1;
      step();
      io_bus.ack = 1'b0;
      chk("sh_valid", valid_out, 1);
      chk("sh_wb_en", wb_en_out, 0);
      chk("sh_data", wb_data_out, 32'h8000_0002);
      chk("sh_df_en", df_mem_enable, 0);
      chk("sh_io_off", io_bus.req, 0);

      // SB a=1 to memory
      drive(1'b1, 32'h210, IW_SB, 32'h1, 32'h1234_56A5, 1'b1, 1'b0, 5'd0);
      step();
      idle();
      chk("sb_be", mem_bus.be, 4'b0010);
      chk("sb_wdata", mem_bus.wdata, 32'hA5A5_A5A5);
      mem_bus.ack = 1'b1;
      step();
      mem_bus.ack = 1'b0;
      chk("sb_valid", valid_out, 1);

      // LHU a=2
      drive(1'b1, 32'h220, IW_LHU, 32'h2, 32'h0, 1'b0, 1'b1, 5'd8);
      step();
      idle();
      mem_bus.rdata = 32'h8001_7FFF; mem_bus.ack = 1'b1;
      step();
      mem_bus.ack = 1'b0;
      chk("lhu_data", wb_data_out, 32'h0000_8001);

      // LW a=0x10 with no ack: fault after 16 WAIT cycles
      drive(1'b1, 32'h300, IW_LW, 32'h10, 32'h0, 1'b0, 1'b1, 5'd9);
      step();
      idle();
      chk("to_addr", mem_bus.addr, 30'h4);
      for (int i = 0; i < 15; i++) step();
      chk("to_w16_req", mem_bus.req, 1);
      chk("to_w16_valid", valid_out, 0);
      step();
      chk("to_fault", fault_out, 1);
      chk("to_valid", valid_out, 1);
      chk("to_req_off", mem_bus.req, 0);
      chk("to_wb_en", wb_en_out, 0);
      chk("to_stall", stall_out, 0);
      step();
      chk("to_pulse", fault_out, 0);

      // Same access, ack in the 16th WAIT cycle wins
      drive(1'b1, 32'h304, IW_LW, 32'h10, 32'h0, 1'b0, 1'b1, 5'd9);
      step();
      idle();
      for (int i = 0; i < 15; i++) step();
      mem_bus.rdata = 32'hCAFE_F00D; mem_bus.ack = 1'b1;
      step();
      mem_bus.ack = 1'b0;
      chk("ack16_fault", fault_out, 0);
      chk("ack16_valid", valid_out, 1);
      chk("ack16_data", wb_data_out, 32'hCAFE_F00D);

      // LH a=0x21 misaligned, then LW back-to-back
      drive(1'b1, 32'h400, IW_LH, 32'h21, 32'h0, 1'b0, 1'b1, 5'd10);
      step();
      drive(1'b1, 32'h404, IW_LW, 32'h24, 32'h0, 1'b0, 1'b1, 5'd11);
      chk("mis_flag", misalign_out, 1);
      chk("mis_valid", valid_out, 1);
      chk("mis_wb_en", wb_en_out, 0);
      chk("mis_mem_req", mem_bus.req, 0);
      chk("mis_io_req", io_bus.req, 0);
      chk("mis_stall", stall_out, 0);
      step();
      idle();
      chk("b2b_req", mem_bus.req, 1);
      chk("b2b_addr", mem_bus.addr, 30'h9);
      chk("b2b_mis_pulse", misalign_out, 0);
      mem_bus.rdata = 32'h1234_5678; mem_bus.ack = 1'b1;
      step();
      mem_bus.ack = 1'b0;
      chk("b2b_data", wb_data_out, 32'h1234_5678);
      chk("b2b_pc", pc_out, 32'h404);

      // Unsupported width 011 treated as misaligned
      drive(1'b1, 32'h410, IW_LX3, 32'h0, 32'h0, 1'b0, 1'b1, 5'd12);
      step();
      idle();
      chk("f3_011_mis", misalign_out, 1);
      chk("f3_011_req", mem_bus.req, 0);

      // Reset in the middle of WAIT, late ack afterwards
      drive(1'b1, 32'h500, IW_LW, 32'h40, 32'h0, 1'b0, 1'b1, 5'd13);
      step();
      idle();
      chk("rw_req", mem_bus.req, 1);
      reset = 1'b1;
      #1;
      chk("rw_async_req", mem_bus.req, 0);
      chk("rw_async_stall", stall_out, 0);
      chk("rw_async_state", state_dbg, 0);
      step();
      reset = 1'b0;
      mem_bus.rdata = 32'hDEAD_BEEF; mem_bus.ack = 1'b1;
      step();
      mem_bus.ack = 1'b0;
      chk("rw_valid", valid_out, 0);
      chk("rw_req_off", mem_bus.req, 0);
      chk("rw_data", wb_data_out, 0);
      chk("rw_pc", pc_out, 0);
      step();
      chk("rw_valid2", valid_out, 0);
      chk("rw_state", state_dbg, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
